// File: rtl/cpu_pkg.sv
// cpu_pkg: opcodes, IR field positions, sequencer states and instruction classes
package cpu_pkg;
   localparam int OPW   = 5;
   localparam int ALUW  = 5;
   localparam int OP_LO = 27;
   localparam int RA_LO = 23;
   localparam int RB_LO = 19;
   localparam int RC_LO = 15;
   localparam int REG_W = 4;
   localparam logic [OPW-1:0] OP_LD   = 5'b00000;
   localparam logic [OPW-1:0] OP_LDI  = 5'b00001;
   localparam logic [OPW-1:0] OP_ST   = 5'b00010;
   localparam logic [OPW-1:0] OP_ADD  = 5'b00011;
   localparam logic [OPW-1:0] OP_SUB  = 5'b00100;
   localparam logic [OPW-1:0] OP_AND  = 5'b00101;
   localparam logic [OPW-1:0] OP_OR   = 5'b00110;
   localparam logic [OPW-1:0] OP_ROR  = 5'b00111;
   localparam logic [OPW-1:0] OP_ROL  = 5'b01000;
   localparam logic [OPW-1:0] OP_SHR  = 5'b01001;
   localparam logic [OPW-1:0] OP_SHRA = 5'b01010;
   localparam logic [OPW-1:0] OP_SHL  = 5'b01011;
   localparam logic [OPW-1:0] OP_ADDI = 5'b01100;
   localparam logic [OPW-1:0] OP_ANDI = 5'b01101;
   localparam logic [OPW-1:0] OP_ORI  = 5'b01110;
   localparam logic [OPW-1:0] OP_MUL  = 5'b01111;
   localparam logic [OPW-1:0] OP_DIV  = 5'b10000;
   localparam logic [OPW-1:0] OP_BR   = 5'b10010;
   localparam logic [OPW-1:0] OP_NOP  = 5'b11000;
   localparam logic [OPW-1:0] OP_HALT = 5'b11001;
   typedef enum logic [3:0] {RST, T0, T1, T2, T3, T4, T5, T6, T7, HALT} state_t;
   typedef enum logic [3:0] {C_RTYPE, C_IMM, C_MULDIV, C_LD, C_LDI, C_ST, C_BR, C_NOP, C_HALT} cls_e;
endpackage

// File: rtl/op_decoder.sv
// op_decoder: maps an opcode to its execution class; unknown opcodes behave as NOP
module op_decoder
   import cpu_pkg::*;
(
   input  logic [OPW-1:0] op,
   output cls_e           cls
);
   assign cls = (op >= OP_ADD  && op <= OP_SHL) ? C_RTYPE :
                (op >= OP_ADDI && op <= OP_ORI) ? C_IMM :
                (op == OP_MUL  || op == OP_DIV) ? C_MULDIV :
                (op == OP_LD)   ? C_LD :
                (op == OP_LDI)  ? C_LDI :
                (op == OP_ST)   ? C_ST :
                (op == OP_BR)   ? C_BR :
                (op == OP_HALT) ? C_HALT : C_NOP;
endmodule

// File: rtl/control_sequencer.sv
// control_sequencer: hardwired fetch/execute step sequencer driving the datapath strobes
module control_sequencer
   import cpu_pkg::*;
(
   input  logic            clk,
   input  logic            clr,
   input  logic [31:0]     ir,
   input  logic            con_ff,
   input  logic            mem_rdy,
   input  logic            stop,
   output logic            pc_out,
   output logic            zhigh_out,
   output logic            zlow_out,
   output logic            hi_out,
   output logic            lo_out,
   output logic            mdr_out,
   output logic            c_out,
   output logic            mar_in,
   output logic            pc_in,
   output logic            mdr_in,
   output logic            ir_in,
   output logic            y_in,
   output logic            z_in,
   output logic            hi_in,
   output logic            lo_in,
   output logic            con_in,
   output logic            inc_pc,
   output logic            read,
   output logic            write,
   output logic            gra,
   output logic            grb,
   output logic            grc,
   output logic            r_in,
   output logic            r_out,
   output logic            ba_out,
   output logic [ALUW-1:0] alu_op,
   output logic            run
);
   state_t         state, next, done;
   cls_e           cls;
   logic [OPW-1:0] op;
   logic           held, mem_cls, unused_ir;
   assign op        = ir[OP_LO +: OPW];
   assign unused_ir = ^ir[OP_LO-1:0];
   assign mem_cls   = cls == C_LD || cls == C_LDI || cls == C_ST;
   assign run       = state != RST && state != HALT;
   op_decoder u_dec (.op(op), .cls(cls));
   // state register; held marks the T1 wait cycles after the first so pc_in pulses once
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         state <= RST;
         held  <= 1'b0;
      end else begin
         state <= next;
         held  <= state == T1 && !mem_rdy;
      end
   end
   // next-state selection and Moore strobe decode of the current step
   always_comb begin
      next = state;
      done = stop ? HALT : T0;
      {pc_out, zhigh_out, zlow_out, hi_out, lo_out, mdr_out, c_out, mar_in, pc_in, mdr_in,
       ir_in, y_in, z_in, hi_in, lo_in, con_in, inc_pc, read, write, gra, grb, grc,
       r_in, r_out, ba_out} = '0;
      alu_op = '0;
      case (state)
         RST: next = T0;
         T0: begin
            next   = T1;
            pc_out = 1'b1;
            mar_in = 1'b1;
            inc_pc = 1'b1;
            z_in   = 1'b1;
         end
         T1: begin
            next     = mem_rdy ? T2 : T1;
            zlow_out = 1'b1;
            pc_in    = !held;
            read     = 1'b1;
            mdr_in   = 1'b1;
         end
         T2: begin
            next    = cls == C_HALT ? HALT : cls == C_NOP ? done : T3;
            mdr_out = 1'b1;
            ir_in   = 1'b1;
         end
         T3: begin
            next   = T4;
            gra    = cls == C_MULDIV || cls == C_BR;
            grb    = !(cls == C_MULDIV || cls == C_BR);
            r_out  = !mem_cls;
            ba_out = mem_cls;
            y_in   = cls != C_BR;
            con_in = cls == C_BR;
         end
         T4: begin
            next   = T5;
            pc_out = cls == C_BR;
            y_in   = cls == C_BR;
            z_in   = cls != C_BR;
            grc    = cls == C_RTYPE;
            grb    = cls == C_MULDIV;
            r_out  = cls == C_RTYPE || cls == C_MULDIV;
            c_out  = cls == C_IMM || mem_cls;
            alu_op = cls == C_BR ? '0 : mem_cls ? OP_ADD : op;
         end
         T5: begin
            next     = (cls == C_RTYPE || cls == C_IMM || cls == C_LDI) ? done : T6;
            c_out    = cls == C_BR;
            z_in     = cls == C_BR;
            alu_op   = cls == C_BR ? OP_ADD : '0;
            zlow_out = cls != C_BR;
            lo_in    = cls == C_MULDIV;
            mar_in   = cls == C_LD || cls == C_ST;
            gra      = cls == C_RTYPE || cls == C_IMM || cls == C_LDI;
            r_in     = cls == C_RTYPE || cls == C_IMM || cls == C_LDI;
         end
         T6: begin
            next      = cls == C_LD ? (mem_rdy ? T7 : T6) : cls == C_ST ? T7 : done;
            zhigh_out = cls == C_MULDIV;
            hi_in     = cls == C_MULDIV;
            zlow_out  = cls == C_BR;
            pc_in     = cls == C_BR && con_ff;
            read      = cls == C_LD;
            mdr_in    = cls == C_LD || cls == C_ST;
            gra       = cls == C_ST;
            r_out     = cls == C_ST;
         end
         T7: begin
            next    = (cls == C_ST && !mem_rdy) ? T7 : done;
            mdr_out = cls == C_LD;
            gra     = cls == C_LD;
            r_in    = cls == C_LD;
            write   = cls == C_ST;
         end
         default: next = state;
      endcase
   end
endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: random and directed instruction streams checked against a step-table model
module tb_control_sequencer;
   localparam logic [24:0] PC_OUT    = 25'd1 << 24;
   localparam logic [24:0] ZHIGH_OUT = 25'd1 << 23;
   localparam logic [24:0] ZLOW_OUT  = 25'd1 << 22;
   localparam logic [24:0] MDR_OUT   = 25'd1 << 19;
   localparam logic [24:0] C_OUT     = 25'd1 << 18;
   localparam logic [24:0] MAR_IN    = 25'd1 << 17;
   localparam logic [24:0] PC_IN     = 25'd1 << 16;
   localparam logic [24:0] MDR_IN    = 25'd1 << 15;
   localparam logic [24:0] IR_IN     = 25'd1 << 14;
   localparam logic [24:0] Y_IN      = 25'd1 << 13;
   localparam logic [24:0] Z_IN      = 25'd1 << 12;
   localparam logic [24:0] HI_IN     = 25'd1 << 11;
   localparam logic [24:0] LO_IN     = 25'd1 << 10;
   localparam logic [24:0] CON_IN    = 25'd1 << 9;
   localparam logic [24:0] INC_PC    = 25'd1 << 8;
   localparam logic [24:0] READ      = 25'd1 << 7;
   localparam logic [24:0] WRITE     = 25'd1 << 6;
   localparam logic [24:0] GRA       = 25'd1 << 5;
   localparam logic [24:0] GRB       = 25'd1 << 4;
   localparam logic [24:0] GRC       = 25'd1 << 3;
   localparam logic [24:0] R_IN      = 25'd1 << 2;
   localparam logic [24:0] R_OUT     = 25'd1 << 1;
   localparam logic [24:0] BA_OUT    = 25'd1 << 0;
   localparam int K_R = 0, K_IMM = 1, K_MD = 2, K_LD = 3, K_LDI = 4, K_ST = 5, K_BR = 6, K_NOP = 7, K_HALT = 8;
   logic        clk = 1'b0, clr = 1'b0, con_ff = 1'b0, mem_rdy = 1'b0, stop = 1'b0;
   logic [31:0] ir = '0;
   logic pc_out, zhigh_out, zlow_out, hi_out, lo_out, mdr_out, c_out, mar_in, pc_in, mdr_in;
   logic ir_in, y_in, z_in, hi_in, lo_in, con_in, inc_pc, read, write, gra, grb, grc;
   logic r_in, r_out, ba_out, run;
   logic [4:0]  alu_op;
   logic [30:0] obs;
   int n_tests = 0, n_fail = 0;
   typedef struct {logic [30:0] e; bit mem; int waits;} step_t;
   step_t q[$];

   control_sequencer dut (
      .clk(clk), .clr(clr), .ir(ir), .con_ff(con_ff), .mem_rdy(mem_rdy), .stop(stop),
      .pc_out(pc_out), .zhigh_out(zhigh_out), .zlow_out(zlow_out), .hi_out(hi_out),
      .lo_out(lo_out), .mdr_out(mdr_out), .c_out(c_out), .mar_in(mar_in), .pc_in(pc_in),
      .mdr_in(mdr_in), .ir_in(ir_in), .y_in(y_in), .z_in(z_in), .hi_in(hi_in), .lo_in(lo_in),
      .con_in(con_in), .inc_pc(inc_pc), .read(read), .write(write), .gra(gra), .grb(grb),
      .grc(grc), .r_in(r_in), .r_out(r_out), .ba_out(ba_out), .alu_op(alu_op), .run(run)
   );

   assign obs = {run, alu_op, pc_out, zhigh_out, zlow_out, hi_out, lo_out, mdr_out, c_out,
                 mar_in, pc_in, mdr_in, ir_in, y_in, z_in, hi_in, lo_in, con_in, inc_pc,
                 read, write, gra, grb, grc, r_in, r_out, ba_out};

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [30:0] got, input logic [30:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [30:0] w(input logic [24:0] s, input logic [4:0] a = 5'd0);
      return {1'b1, a, s};
   endfunction

   function automatic int cls_of(input logic [4:0] op);
      if (op >= 5'd3 && op <= 5'd11) return K_R;
      if (op >= 5'd12 && op <= 5'd14) return K_IMM;
      if (op == 5'd15 || op == 5'd16) return K_MD;
      if (op == 5'd0) return K_LD;
      if (op == 5'd1) return K_LDI;
      if (op == 5'd2) return K_ST;
      if (op == 5'd18) return K_BR;
      if (op == 5'd25) return K_HALT;
      return K_NOP;
   endfunction

   task automatic add(input logic [30:0] e, input bit mem = 1'b0, input int waits = 0);
      step_t s;
      s.e = e;
      s.mem = mem;
      s.waits = waits;
      q.push_back(s);
   endtask

   // one clock: drive inputs, compare at the falling edge, return just after the next rising edge
   task automatic cyc(input string tag, input logic [30:0] e, input bit mr, input bit st);
      mem_rdy = mr;
      stop = st;
      @(negedge clk);
      check(tag, obs, e);
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      clr = 1'b0;
      stop = 1'b0;
      mem_rdy = 1'($urandom);
      #1;
      check("rst_async", obs, '0);
      @(posedge clk);
      #1;
      check("rst_hold", obs, '0);
      clr = 1'b1;
      @(posedge clk);
      #1;
   endtask

   // model: expand an instruction into its step table, then play it cycle by cycle
   task automatic run_instr(input logic [31:0] instr, input bit cf, input bit st, input int w1, input int wm);
      logic [4:0] op;
      int c, nw;
      bit last;
      op = instr[31:27];
      c = cls_of(op);
      ir = instr;
      con_ff = cf;
      q.delete();
      add(w(PC_OUT | MAR_IN | INC_PC | Z_IN));
      add(w(ZLOW_OUT | PC_IN | READ | MDR_IN), 1'b1, w1);
      add(w(MDR_OUT | IR_IN));
      if (c == K_R || c == K_IMM) begin
         add(w(GRB | R_OUT | Y_IN));
         add(c == K_R ? w(GRC | R_OUT | Z_IN, op) : w(C_OUT | Z_IN, op));
         add(w(ZLOW_OUT | GRA | R_IN));
      end else if (c == K_MD) begin
         add(w(GRA | R_OUT | Y_IN));
         add(w(GRB | R_OUT | Z_IN, op));
         add(w(ZLOW_OUT | LO_IN));
         add(w(ZHIGH_OUT | HI_IN));
      end else if (c == K_LD || c == K_LDI || c == K_ST) begin
         add(w(GRB | BA_OUT | Y_IN));
         add(w(C_OUT | Z_IN, 5'b00011));
         if (c == K_LDI) add(w(ZLOW_OUT | GRA | R_IN));
         else begin
            add(w(ZLOW_OUT | MAR_IN));
            if (c == K_LD) begin
               add(w(READ | MDR_IN), 1'b1, wm);
               add(w(MDR_OUT | GRA | R_IN));
            end else begin
               add(w(GRA | R_OUT | MDR_IN));
               add(w(WRITE), 1'b1, wm);
            end
         end
      end else if (c == K_BR) begin
         add(w(GRA | R_OUT | CON_IN));
         add(w(PC_OUT | Y_IN));
         add(w(C_OUT | Z_IN, 5'b00011));
         add(w(ZLOW_OUT | (cf ? PC_IN : 25'd0)));
      end
      foreach (q[i]) begin
         nw = q[i].mem ? q[i].waits : 0;
         for (int k = 0; k <= nw; k++) begin
            last = (i == q.size() - 1) && (k == nw);
            cyc($sformatf("op%02h_T%0d", op, i), k > 0 ? (q[i].e & ~{6'd0, PC_IN}) : q[i].e,
                q[i].mem ? (k == nw) : 1'($urandom), last ? st : 1'($urandom));
         end
      end
      if (c == K_HALT || st) begin
         for (int k = 0; k < 20; k++) cyc("halted", '0, 1'($urandom), 1'($urandom));
         do_reset();
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      @(posedge clk);
      #1;
      do_reset();
      run_instr(32'h28918000, 1'b0, 1'b0, 0, 0);
      run_instr(32'h28918000, 1'b0, 1'b0, 3, 0);
      run_instr(32'h00800000, 1'b0, 1'b0, 0, 0);
      run_instr(32'h10800000, 1'b0, 1'b0, 0, 0);
      run_instr(32'h10800000, 1'b1, 1'b0, 1, 2);
      run_instr(32'h00800000, 1'b1, 1'b0, 2, 3);
      run_instr(32'h90800000, 1'b0, 1'b0, 0, 0);
      run_instr(32'h90800000, 1'b1, 1'b0, 0, 0);
      run_instr(32'hC0000000, 1'b0, 1'b0, 0, 0);
      // MUL aborted by clr in T4
      ir = 32'h78918000;
      cyc("mul_T0", w(PC_OUT | MAR_IN | INC_PC | Z_IN), 1'b1, 1'b0);
      cyc("mul_T1", w(ZLOW_OUT | PC_IN | READ | MDR_IN), 1'b1, 1'b0);
      cyc("mul_T2", w(MDR_OUT | IR_IN), 1'b1, 1'b0);
      cyc("mul_T3", w(GRA | R_OUT | Y_IN), 1'b1, 1'b0);
      #2;
      check("mul_T4", obs, w(GRB | R_OUT | Z_IN, 5'b01111));
      clr = 1'b0;
      #1;
      check("mul_abort", obs, '0);
      @(posedge clk);
      #1;
      check("mul_abort_hold", obs, '0);
      clr = 1'b1;
      @(posedge clk);
      #1;
      run_instr(32'h78918000, 1'b0, 1'b0, 0, 0);
      run_instr(32'hC8000000, 1'b0, 1'b0, 0, 0);
      run_instr(32'h18918000, 1'b0, 1'b1, 0, 0);
      repeat (60) begin
         run_instr({5'($urandom_range(0, 31)), 27'($urandom)}, 1'($urandom), $urandom_range(0, 7) == 0,
                   $urandom_range(0, 3), $urandom_range(0, 3));
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
Hardwired control unit for the bus-based datapath. Generates the per-step control strobes (register-out/in enables, ALU operation, memory read/write) that drive the datapath through fetch T0-T2 and execute T3-T7. Decodes IR fields and sequences them. Handshakes with memory via mem_rdy. It sits beside the datapath and replaces any external stimulus that hand-drives those strobes.

Parameters:
OPW, 5, opcode width, IR[31:27]
ALUW, 5, width of alu_op; equals the opcode encoding for ALU operations

Ports:
clk  in  1  system clock, rising edge
clr  in  1  reset, asynchronous, active-low
ir  in  32  instruction register contents from datapath
con_ff  in  1  branch-condition flag from datapath
mem_rdy  in  1  memory completes the current read/write this cycle
stop  in  1  request halt at next instruction boundary
pc_out, zhigh_out, zlow_out, hi_out, lo_out, mdr_out, c_out  out  1 each  bus drivers
mar_in, pc_in, mdr_in, ir_in, y_in, z_in, hi_in, lo_in, con_in, inc_pc  out  1 each  register loads
read, write  out  1 each  memory strobes
gra, grb, grc  out  1 each  select IR Ra[26:23] / Rb[22:19] / Rc[18:15] for the register file
r_in, r_out, ba_out  out  1 each  selected-register load / drive / base-address drive (R0 reads as 0)
alu_op  out  5  operation to ALU
run  out  1  high while executing; low in reset and HALT

Behaviour:
- Clocking and reset: one clock. clr is asynchronous and active-low.
- clr low: state = RST, all outputs 0, run = 0, immediately, including mid-instruction; the instruction in progress is abandoned.
- First posedge after clr rises: RST->T0, run = 1.
- Outputs are a Moore decode of the state register plus ir and con_ff. Every strobe not listed for a step is 0.
- Fetch:
  - T0: pc_out, mar_in, inc_pc, z_in.
  - T1: zlow_out, pc_in (first cycle only), read, mdr_in. Hold in T1 until mem_rdy = 1 is sampled. read stays high throughout the hold.
  - T2: mdr_out, ir_in.
- Opcodes: ADD 00011, SUB 00100, AND 00101, OR 00110, ROR 00111, ROL 01000, SHR 01001, SHRA 01010, SHL 01011, ADDI 01100, ANDI 01101, ORI 01110, MUL 01111, DIV 10000, LD 00000, LDI 00001, ST 00010, BR 10010, NOP 11000, HALT 11001. Any other opcode executes as NOP.
- R-type: T3 grb, r_out, y_in; T4 grc, r_out, alu_op = opcode, z_in; T5 zlow_out, gra, r_in; then T0.
- Immediate: T3 as R-type; T4 c_out, alu_op = opcode, z_in; T5 as R-type.
- MUL/DIV: T3 gra, r_out, y_in; T4 grb, r_out, alu_op, z_in; T5 zlow_out, lo_in; T6 zhigh_out, hi_in.
- LD/LDI/ST, T3 and T4: T3 grb, ba_out, y_in; T4 c_out, alu_op = ADD, z_in.
- LDI: T5 zlow_out, gra, r_in.
- LD: T5 zlow_out, mar_in; T6 read, mdr_in, waits for mem_rdy; T7 mdr_out, gra, r_in.
- ST: T5 zlow_out, mar_in; T6 gra, r_out, mdr_in (read = 0); T7 write, waits for mem_rdy.
- BR: T3 gra, r_out, con_in; T4 pc_out, y_in; T5 c_out, alu_op = ADD, z_in; T6 zlow_out, and pc_in only if con_ff = 1.
- NOP: T2->T0.
- HALT: T2->HALT; run = 0; stays until clr.
- stop: sampled only on the cycle that would enter T0. If 1, go to HALT instead.
- Memory wait: read/write held continuously until the cycle where mem_rdy = 1. Advance on that edge; with mem_rdy tied high, each memory step takes exactly one cycle. mem_rdy outside memory steps is ignored.
- Zero-wait latency in cycles, T0 to the next T0: R-type/immediate 6, LDI 6, MUL/DIV 7, BR 7, LD 8, ST 8, NOP 3.

Decomposition:
- Shared package cpu_pkg:
  - opcode constants
  - state enum: RST, T0-T7, HALT
  - IR field position constants
- Sub-module op_decoder (combinational): opcode to class (RTYPE, IMM, MULDIV, LD, LDI, ST, BR, NOP, HALT).
- control_sequencer holds the FSM and the output decode.

Test Plan:
- Reset, mem_rdy = 1, ir = 0x28918000 (AND, Ra = 1, Rb = 2, Rc = 3) -> T0..T5 over 6 cycles; T4 alu_op = 00101 with grc, r_out; T5 gra, r_in; back in T0 on cycle 7.
- Same instruction, mem_rdy low for 3 cycles in T1 -> read, mdr_in high 4 cycles, pc_in high only on the first; T2 follows mem_rdy.
- LD ir = 0x00800000, mem_rdy = 1 -> T5 mar_in; T6 read; T7 mdr_out, gra, r_in; 8 cycles total. ST -> T7 write = 1, read = 0.
- BR with con_ff = 0 -> T6 shows zlow_out with pc_in = 0. With con_ff = 1 -> pc_in = 1.
- Drive clr low during T4 of MUL -> all outputs 0 asynchronously, run = 0; after release T0 on the first edge.
- HALT opcode 11001 -> run falls after T2, no strobes for 20 cycles. Separately, stop = 1 during an ADD's T5 -> HALT instead of T0.
